// File: rtl/memoria_pkg.sv
// Shared types and constants for the write-back controller that feeds the 16x16 register bank.
package memoria_pkg;

    localparam int NREG   = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // One queued bank write; the data field fixes the bank data width.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/memoria_wb_ctrl_if.sv
// Request/bank-port bundle between a write requester and memoria_wb_ctrl.
// MEMORIA_WB_STATS_EN adds the wr_count statistic.
interface memoria_wb_ctrl_if
    import memoria_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = 4
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [ADDR_W-1:0]        in_addr;
    logic [N-1:0]             in_data;
    logic                     clear_req;
    logic                     busy;
    logic [$clog2(DEPTH):0]   level;
    logic                     w;
    logic [ADDR_W-1:0]        select_register;
    logic [N-1:0]             s;
`ifdef MEMORIA_WB_STATS_EN
    logic [15:0]              wr_count;
`endif

    modport master (
        output in_valid, in_addr, in_data, clear_req,
`ifdef MEMORIA_WB_STATS_EN
        input  wr_count,
`endif
        input  in_ready, busy, level, w, select_register, s
    );

    modport slave (
        input  in_valid, in_addr, in_data, clear_req,
`ifdef MEMORIA_WB_STATS_EN
        output wr_count,
`endif
        output in_ready, busy, level, w, select_register, s
    );

endinterface

// File: rtl/memoria_wb_fifo.sv
// DEPTH-entry synchronous FIFO holding pending bank writes; flush wins over pop,
// while a push on the flush edge survives as the sole entry.
module memoria_wb_fifo
    import memoria_pkg::*;
#(
    parameter int W     = $bits(wb_req_t),
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic          w_do_push;
    logic          w_do_pop;
    logic [AW-1:0] w_wr_addr;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !flush;
    assign w_wr_addr = flush ? '0 : r_wr_ptr;

    // Head is read combinationally so the pop edge can register it straight into the bank port.
    assign dout = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_do_push ? AW'(1) : '0;
            r_level  <= w_do_push ? LW'(1) : '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/memoria_wb_ctrl.sv
// Write-back controller: queues register writes and drives the bank write port, with a CLEAR sweep.
// Define MEMORIA_WB_STATS_EN to add the saturating wr_count statistic.
module memoria_wb_ctrl
    import memoria_pkg::*;
#(
    parameter int N     = DATA_W,
    parameter int DEPTH = 4,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    memoria_wb_ctrl_if.slave    bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_w;
    logic              w_w_next;
    logic [ADDR_W-1:0] r_sel;
    logic [ADDR_W-1:0] w_sel_next;
    logic [N-1:0]      r_s;
    logic [N-1:0]      w_s_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    wb_req_t           w_din;
    wb_req_t           w_head;
    logic              w_full;
    logic              w_empty;
    logic [LW-1:0]     w_level;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;

    assign w_din   = '{addr: bus.in_addr, data: bus.in_data};
    assign w_push  = bus.in_valid && !w_full;
    // A clear request supersedes whatever would have been popped on that edge.
    assign w_flush = (r_state == ST_IDLE) && bus.clear_req;
    assign w_pop   = (r_state == ST_IDLE) && !bus.clear_req && !w_empty;

    memoria_wb_fifo #(
        .W     ($bits(wb_req_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_comb begin
        w_state_next = r_state;
        w_w_next     = 1'b0;
        w_sel_next   = r_sel;
        w_s_next     = r_s;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end else if (!w_empty) begin
                    w_w_next   = 1'b1;
                    w_sel_next = w_head.addr;
                    w_s_next   = w_head.data;
                end
            end
            ST_CLEAR: begin
                w_w_next   = 1'b1;
                w_sel_next = r_cnt;
                w_s_next   = '0;
                w_cnt_next = r_cnt + ADDR_W'(1);
                if (r_cnt == ADDR_W'(NREG - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_w     <= 1'b0;
            r_sel   <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_w     <= w_w_next;
            r_sel   <= w_sel_next;
            r_s     <= w_s_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign bus.in_ready        = !w_full;
    assign bus.busy            = (r_state == ST_CLEAR) || !w_empty;
    assign bus.level           = w_level;
    assign bus.w               = r_w;
    assign bus.select_register = r_sel;
    assign bus.s               = r_s;

`ifdef MEMORIA_WB_STATS_EN
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else if (r_w && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign bus.wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_memoria_wb_ctrl.sv
// Directed bench for memoria_wb_ctrl: a vector table for basic draining plus hand sequences
// for the sweep, backpressure, clear/push overlap and mid-sweep reset.
module tb_memoria_wb_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    always #5 clk = ~clk;

    memoria_wb_ctrl_if #(.N(16), .DEPTH(4)) bus ();

    memoria_wb_ctrl #(.N(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v;
        logic [3:0]  a;
        logic [15:0] d;
        logic        clr;
        logic        ew;
        logic [3:0]  esel;
        logic [15:0] es;
        logic [2:0]  elev;
        logic        erdy;
        logic        ebusy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, step_no, act, exp);
        end
    endtask

    // Drive one edge's worth of inputs, then sample #1 after the edge.
    task automatic cyc(input logic v, input logic [3:0] a, input logic [15:0] d, input logic c);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.clear_req = c;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.clear_req = 1'b0;
        step_no++;
    endtask

    task automatic expect_out(input string tag, input logic ew, input logic [3:0] esel,
                              input logic [15:0] es, input logic [2:0] elev,
                              input logic erdy, input logic ebusy);
        $display("step %0d %s: w=%0b sel=%0d s=%04h level=%0d ready=%0b busy=%0b",
                 step_no, tag, bus.w, bus.select_register, bus.s, bus.level, bus.in_ready, bus.busy);
        chk({tag, ".w"},     32'(bus.w),               32'(ew));
        chk({tag, ".sel"},   32'(bus.select_register), 32'(esel));
        chk({tag, ".s"},     32'(bus.s),               32'(es));
        chk({tag, ".level"}, 32'(bus.level),           32'(elev));
        chk({tag, ".ready"}, 32'(bus.in_ready),        32'(erdy));
        chk({tag, ".busy"},  32'(bus.busy),            32'(ebusy));
    endtask

    task automatic idle(); cyc(1'b0, 4'd0, 16'h0, 1'b0); endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.clear_req = 1'b0;

        //                v  addr   data       clr  w  sel    s          lev   rdy busy
        tbl[0] = '{1'b1, 4'd3, 16'h00AA, 1'b0, 1'b0, 4'd0, 16'h0000, 3'd1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd3, 16'h00AA, 3'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd3, 16'h00AA, 3'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 4'd3, 16'h00AA, 3'd1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 4'd2, 16'h0022, 1'b0, 1'b1, 4'd1, 16'h0011, 3'd1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 4'd4, 16'h0044, 1'b0, 1'b1, 4'd2, 16'h0022, 3'd1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd4, 16'h0044, 3'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd4, 16'h0044, 3'd0, 1'b1, 1'b0};

        // Reset held for two edges, then released.
        rst = 1'b0;
        idle();
        idle();
        expect_out("reset", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
`ifdef MEMORIA_WB_STATS_EN
        chk("reset.wr_count", 32'(bus.wr_count), 32'd0);
`endif
        rst = 1'b1;
        idle();
        expect_out("post_reset", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);

        // Single write latency and back-to-back drain with simultaneous push/pop.
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].clr);
            expect_out($sformatf("vec%0d", i), tbl[i].ew, tbl[i].esel, tbl[i].es,
                       tbl[i].elev, tbl[i].erdy, tbl[i].ebusy);
        end

        // Sweep from empty, with a second clear_req mid-sweep that must be ignored.
        cyc(1'b0, 4'd0, 16'h0, 1'b1);
        expect_out("sw_start", 1'b0, 4'd4, 16'h0044, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 4'd0, 16'h0, (i == 5));
            expect_out($sformatf("sweep%0d", i), 1'b1, 4'(i), 16'h0, 3'd0, 1'b1, (i < 15));
        end
        idle();
        expect_out("sw_end", 1'b0, 4'd15, 16'h0, 3'd0, 1'b1, 1'b0);
        idle();
        expect_out("sw_quiet", 1'b0, 4'd15, 16'h0, 3'd0, 1'b1, 1'b0);

        // Pushes during the sweep fill the FIFO; a fifth is refused; drain follows the sweep.
        cyc(1'b0, 4'd0, 16'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i < 5) begin
                cyc(1'b1, 4'(5 + i), 16'(1 + i), 1'b0);
            end else begin
                idle();
            end
            expect_out($sformatf("fill%0d", i), 1'b1, 4'(i), 16'h0,
                       (i < 4) ? 3'(i + 1) : 3'd4, (i < 3), 1'b1);
        end
        for (int j = 0; j < 4; j++) begin
            idle();
            expect_out($sformatf("drain%0d", j), 1'b1, 4'(5 + j), 16'(1 + j),
                       3'(3 - j), 1'b1, (j < 3));
        end
        idle();
        expect_out("drain_end", 1'b0, 4'd8, 16'd4, 3'd0, 1'b1, 1'b0);

        // A queued entry is discarded by a clear on the next edge.
        cyc(1'b1, 4'd10, 16'h1010, 1'b0);
        expect_out("q_push", 1'b0, 4'd8, 16'd4, 3'd1, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 16'h0, 1'b1);
        expect_out("q_flush", 1'b0, 4'd8, 16'd4, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idle();
            expect_out($sformatf("qsw%0d", i), 1'b1, 4'(i), 16'h0, 3'd0, 1'b1, (i < 15));
        end
        idle();
        expect_out("q_gone", 1'b0, 4'd15, 16'h0, 3'd0, 1'b1, 1'b0);

        // Push on the same edge as clear_req survives and lands after the sweep.
        cyc(1'b1, 4'd9, 16'hBEEF, 1'b1);
        expect_out("cp_start", 1'b0, 4'd15, 16'h0, 3'd1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idle();
            expect_out($sformatf("cpsw%0d", i), 1'b1, 4'(i), 16'h0, 3'd1, 1'b1, 1'b1);
        end
        idle();
        expect_out("cp_write", 1'b1, 4'd9, 16'hBEEF, 3'd0, 1'b1, 1'b0);
        idle();
        expect_out("cp_done", 1'b0, 4'd9, 16'hBEEF, 3'd0, 1'b1, 1'b0);

        // Reset while sel=7 is on the bank port, with entries queued.
        cyc(1'b0, 4'd0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc((i < 2), 4'(1 + i), 16'h5A5A, 1'b0);
        end
        expect_out("rs_at7", 1'b1, 4'd7, 16'h0, 3'd2, 1'b1, 1'b1);
        rst = 1'b0;
        idle();
        expect_out("rs_hit", 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            expect_out($sformatf("rs_after%0d", i), 1'b0, 4'd0, 16'h0, 3'd0, 1'b1, 1'b0);
        end

`ifdef MEMORIA_WB_STATS_EN
        // Sweep plus two writes after a reset: counter reaches 18.
        chk("stats.zero", 32'(bus.wr_count), 32'd0);
        cyc(1'b0, 4'd0, 16'h0, 1'b1);
        for (int i = 0; i < 17; i++) idle();
        cyc(1'b1, 4'd1, 16'h0001, 1'b0);
        cyc(1'b1, 4'd2, 16'h0002, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        $display("step %0d stats: wr_count=%0d", step_no, bus.wr_count);
        chk("stats.count", 32'(bus.wr_count), 32'd18);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
